signal_qualifier: RTL and testbench

SIGNAL_QUALIFIER -- requirements
Module: signal_qualifier

---
 rtl/sigqual_pkg.sv | 32 +++
 rtl/signal_qualifier_ch.sv | 143 ++++++++++++++
 rtl/signal_qualifier.sv | 68 ++++++
 tb/tb_signal_qualifier.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sigqual_pkg.sv
// sigqual_pkg
//   Shared definitions for signal_qualifier:
//     qual_state_e : per-channel qualification FSM states
//     us_to_cyc()  : microseconds -> clock cycles at a given clock rate
//     cnt_width()  : hold-counter width for the larger of two cycle counts
package sigqual_pkg;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_QUAL_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_QUAL_LO = 2'd3
    } qual_state_e;

    localparam int unsigned US_PER_S = 1000000;

    function automatic int unsigned us_to_cyc(input int unsigned clk_rate,
                                              input int unsigned us);
        return (clk_rate / US_PER_S) * us;
    endfunction

    // Never returns less than 1 so the counter exists even when both holds are 0.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/signal_qualifier_ch.sv
// signal_qualifier_ch
//   One qualification channel: input synchronizer, LOW/QUAL_HI/HIGH/QUAL_LO
//   FSM with a saturating hold counter, registered ready and edge pulses.
//   Optional feature macro: SIGNAL_QUALIFIER_GLITCH_CNT_EN adds glitch_cnt.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sig_in        : raw asynchronous input
//   ready         : qualified level (registered)
//   rise_pulse    : one-cycle pulse coincident with ready 0->1
//   fall_pulse    : one-cycle pulse coincident with ready 1->0
//   glitch_cnt    : (macro only) saturating count of aborted qualifications
module signal_qualifier_ch
    import sigqual_pkg::*;
#(
    parameter int unsigned RISE_CYC    = 10,
    parameter int unsigned FALL_CYC    = 0,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic       ready,
    output logic       rise_pulse,
    output logic       fall_pulse
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] RISE_LIM = CNT_W'(RISE_CYC);
    localparam logic [CNT_W-1:0] FALL_LIM = CNT_W'(FALL_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    qual_state_e            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic                   ready_nxt, rise_nxt, fall_nxt;

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

    // State register, counter, synchronizer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            state      <= ST_LOW;
            cnt        <= '0;
            ready      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ready      <= ready_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LOW: begin
                if (s) begin
                    if (RISE_CYC <= 1) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_QUAL_HI;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_QUAL_HI: begin
                if (!s) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= RISE_LIM) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (FALL_CYC <= 1) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_QUAL_LO;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_QUAL_LO: begin
                if (s) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= FALL_LIM) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: computed from the next state so ready and its pulses
    // are registered together and land on the same edge.
    always_comb begin
        ready_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_QUAL_LO);
        rise_nxt  = ready_nxt & ~ready;
        fall_nxt  = ~ready_nxt & ready;
    end

`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
    logic abort;

    assign abort = ((state == ST_QUAL_HI) && (state_nxt == ST_LOW)) ||
                   ((state == ST_QUAL_LO) && (state_nxt == ST_HIGH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/signal_qualifier.sv
// signal_qualifier
//   Multi-channel qualifier for slow asynchronous levels (cclk, straps).
//   Each channel must hold high RISE_US before ready asserts and low FALL_US
//   before it deasserts. Optional macro SIGNAL_QUALIFIER_GLITCH_CNT_EN adds
//   the glitch_cnt output (8 bits per channel).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sig_in     : [NUM_CH] raw asynchronous inputs
//   ready      : [NUM_CH] qualified levels
//   rise_pulse : [NUM_CH] one-cycle pulse on ready 0->1
//   fall_pulse : [NUM_CH] one-cycle pulse on ready 1->0
//   all_ready  : registered AND of all ready bits
//   glitch_cnt : [NUM_CH*8] (macro only) aborted-qualification counts
module signal_qualifier
    import sigqual_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 50000000,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned RISE_US     = 10,
    parameter int unsigned FALL_US     = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   sig_in,
    output logic [NUM_CH-1:0]   ready,
    output logic [NUM_CH-1:0]   rise_pulse,
    output logic [NUM_CH-1:0]   fall_pulse,
    output logic                all_ready
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
    ,
    output logic [NUM_CH*8-1:0] glitch_cnt
`endif
);

    localparam int unsigned RISE_CYC = us_to_cyc(CLK_RATE, RISE_US);
    localparam int unsigned FALL_CYC = us_to_cyc(CLK_RATE, FALL_US);
    localparam int unsigned CNT_W    = cnt_width(RISE_CYC, FALL_CYC);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        signal_qualifier_ch #(
            .RISE_CYC    (RISE_CYC),
            .FALL_CYC    (FALL_CYC),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sig_in     (sig_in[i]),
            .ready      (ready[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
            ,
            .glitch_cnt (glitch_cnt[i*8 +: 8])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_ready <= 1'b0;
        end else begin
            all_ready <= &ready;
        end
    end

endmodule

// File: tb/tb_signal_qualifier.sv
// tb_signal_qualifier
//   Directed scoreboard bench for signal_qualifier with CLK_RATE=1 MHz,
//   NUM_CH=2, RISE_US=10, FALL_US=3, SYNC_STAGES=2 (RISE_CYC=10, FALL_CYC=3).
//   Each stimulus cycle pushes the hand-derived outputs expected after the
//   next rising edge; a monitor pops and compares them on the falling edge.
module tb_signal_qualifier;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sig_in;
    logic [1:0] ready;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;
    logic       all_ready;
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
`endif

    signal_qualifier #(
        .CLK_RATE    (1000000),
        .NUM_CH      (2),
        .RISE_US     (10),
        .FALL_US     (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .ready      (ready),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .all_ready  (all_ready)
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] rp;
        logic [1:0] fp;
        logic       ar;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT outputs against the scoreboard each falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready",      16'(ready),      16'(e.r));
                chk("rise_pulse", 16'(rise_pulse), 16'(e.rp));
                chk("fall_pulse", 16'(fall_pulse), 16'(e.fp));
                chk("all_ready",  16'(all_ready),  16'(e.ar));
            end
        end
    end

    // One cycle: drive sig_in, clock, queue expected outputs after that edge
    task automatic step(input logic [1:0] s, input logic [1:0] r,
                        input logic [1:0] rp, input logic [1:0] fp, input logic ar);
        exp_t e;
        sig_in = s;
        @(posedge clk);
        #1;
        e.r  = r;
        e.rp = rp;
        e.fp = fp;
        e.ar = ar;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n, input logic [1:0] s, input logic [1:0] r,
                         input logic [1:0] rp, input logic [1:0] fp, input logic ar);
        for (int i = 0; i < n; i++) step(s, r, rp, fp, ar);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"},      16'(ready),      16'h0);
        chk({tag, " rise_pulse"}, 16'(rise_pulse), 16'h0);
        chk({tag, " fall_pulse"}, 16'(fall_pulse), 16'h0);
        chk({tag, " all_ready"},  16'(all_ready),  16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 2'b00;
        #2;
        chk_all_zero("reset");

        // Reset held, then released with inputs low: no pulses appear
        steps(3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        steps(3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // ch0 held high: ready[0] after exactly 12 cycles, ch1 untouched
        steps(11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        step (    2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
        steps(3,  2'b01, 2'b01, 2'b00, 2'b00, 1'b0);

        // ch0 dropped for 2 cycles then restored: stays ready, no fall pulse
        steps(2, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        steps(6, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
        chk("glitch_cnt after low glitch", glitch_cnt, 16'h0001);
`endif

        // ch0 dropped and held: falls 5 cycles later with a fall pulse
        steps(4, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        step (   2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
        steps(3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // ch0 high for only 9 cycles: never qualifies
        steps(9, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        steps(5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
        chk("glitch_cnt after short high", glitch_cnt, 16'h0002);
`endif
        // then a full high qualifies normally
        steps(11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        step (    2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
        steps(2,  2'b01, 2'b01, 2'b00, 2'b00, 1'b0);

        // Qualify ch1 too: all_ready follows one cycle after ready[1]
        steps(11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        step (    2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        steps(3,  2'b11, 2'b11, 2'b00, 2'b00, 1'b1);

        // Drop ch1: ready[1] falls after 5, all_ready one cycle later
        steps(4, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1);
        step (   2'b01, 2'b01, 2'b00, 2'b10, 1'b1);
        steps(4, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);

        // Raise ch1 and reset while it is mid-qualification
        steps(6, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
`ifdef SIGNAL_QUALIFIER_GLITCH_CNT_EN
        chk("glitch_cnt reset", glitch_cnt, 16'h0000);
`endif
        steps(2, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;

        // After release both channels need the full 12 cycles again
        steps(11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        step (    2'b11, 2'b11, 2'b11, 2'b00, 1'b0);
        steps(2,  2'b11, 2'b11, 2'b00, 2'b00, 1'b1);

        @(negedge clk);
        #1;
        chk("scoreboard drained", 16'(exp_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
